// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit
// Description : RV64 execute-stage branch resolution. Selects signed/unsigned
//               compare, resolves the actual outcome, detects mispredictions,
//               holds a PC redirect with a one-cycle flush, and trains a
//               2-bit saturating branch history table read by fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
  parameter int XLEN        = 64,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             resolve_valid,
  output logic             resolve_ready,
  input  logic [XLEN-1:0]  resolve_pc,
  input  logic [2:0]       funct3,
  input  logic             is_jump,
  input  logic [XLEN-1:0]  target,
  input  logic             pred_taken,
  input  logic [XLEN-1:0]  pred_target,
  output logic             branch_unsigned,
  input  logic             branch_equals,
  input  logic             branch_less_than,
  input  logic [XLEN-1:0]  lookup_pc,
  output logic             predict_taken,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  input  logic             redirect_ready,
  output logic             flush,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } state_t;

  state_t            state;
  logic [1:0]        bht [BHT_ENTRIES];

  logic              accept;
  logic              legal;
  logic              taken;
  logic              mispredict;
  logic [XLEN-1:0]   next_pc;
  logic [IDX_W-1:0]  upd_idx;
  logic [IDX_W-1:0]  look_idx;
  logic [1:0]        upd_old;
  logic [1:0]        upd_new;
  logic              bht_we;
  logic              unused_lookup_bits;

  // Funct3 bit 1 distinguishes BLTU/BGEU from BLT/BGE for the comparator.
  assign branch_unsigned = funct3[1];

  // A redirect in flight blocks further resolutions.
  assign resolve_ready = !redirect_valid;
  assign accept        = resolve_valid && resolve_ready;

  // Actual branch outcome from funct3 and comparator flags; jumps override.
  always_comb begin
    legal = 1'b1;
    taken = 1'b0;
    if (is_jump) begin
      taken = 1'b1;
    end else begin
      case (funct3)
        3'b000:          taken = branch_equals;
        3'b001:          taken = !branch_equals;
        3'b100, 3'b110:  taken = branch_less_than;
        3'b101, 3'b111:  taken = !branch_less_than;
        default: begin
          legal = 1'b0;
          taken = 1'b0;
        end
      endcase
    end
  end

  // Fall-through address wraps naturally at 2^XLEN.
  assign next_pc    = taken ? target : (resolve_pc + XLEN'(4));
  assign mispredict = legal &&
                      ((pred_taken != taken) || (taken && (pred_target != target)));

  // Prediction read is from the register array, so a same-cycle update to
  // the same index is not visible until after the edge.
  assign look_idx      = lookup_pc[IDX_W+1:2];
  assign predict_taken = bht[look_idx][1];
  assign unused_lookup_bits = ^{lookup_pc[XLEN-1:IDX_W+2], lookup_pc[1:0]};

  // Saturating counter next value for the resolving branch's entry.
  assign upd_idx = resolve_pc[IDX_W+1:2];
  assign upd_old = bht[upd_idx];
  assign bht_we  = accept && legal && !is_jump;

  always_comb begin
    upd_new = upd_old;
    if (taken) begin
      if (upd_old != 2'b11) upd_new = upd_old + 2'b01;
    end else begin
      if (upd_old != 2'b00) upd_new = upd_old - 2'b01;
    end
  end

  // BHT storage: every counter starts weakly not-taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
    end else if (bht_we) begin
      bht[upd_idx] <= upd_new;
    end
  end

  // Redirect FSM with registered redirect, flush and mispredict counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      redirect_valid   <= 1'b0;
      redirect_pc      <= '0;
      flush            <= 1'b0;
      mispredict_count <= '0;
    end else begin
      flush <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept && mispredict) begin
            state            <= ST_REDIRECT;
            redirect_valid   <= 1'b1;
            redirect_pc      <= next_pc;
            flush            <= 1'b1;
            mispredict_count <= mispredict_count + CNT_W'(1);
          end
        end
        ST_REDIRECT: begin
          if (redirect_ready) begin
            state          <= ST_IDLE;
            redirect_valid <= 1'b0;
          end
        end
        default: begin
          state          <= ST_IDLE;
          redirect_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve_unit
// Description : Self-checking bench for branch_resolve_unit: directed
//               scenarios plus randomized traffic against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        resolve_valid = 1'b0;
  logic        resolve_ready;
  logic [63:0] resolve_pc = '0;
  logic [2:0]  funct3 = '0;
  logic        is_jump = 1'b0;
  logic [63:0] target = '0;
  logic        pred_taken = 1'b0;
  logic [63:0] pred_target = '0;
  logic        branch_unsigned;
  logic        branch_equals = 1'b0;
  logic        branch_less_than = 1'b0;
  logic [63:0] lookup_pc = '0;
  logic        predict_taken;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        redirect_ready = 1'b1;
  logic        flush;
  logic [31:0] mispredict_count;

  int n_vec = 0;
  int n_err = 0;

  branch_resolve_unit #(.XLEN(64), .BHT_ENTRIES(64), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .resolve_valid(resolve_valid), .resolve_ready(resolve_ready),
    .resolve_pc(resolve_pc), .funct3(funct3), .is_jump(is_jump),
    .target(target), .pred_taken(pred_taken), .pred_target(pred_target),
    .branch_unsigned(branch_unsigned), .branch_equals(branch_equals),
    .branch_less_than(branch_less_than), .lookup_pc(lookup_pc),
    .predict_taken(predict_taken), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .redirect_ready(redirect_ready),
    .flush(flush), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    resolve_valid = 1'b0;
    is_jump       = 1'b0;
    funct3        = 3'b000;
  endtask

  task automatic drive(input logic [63:0] pc, input logic [2:0] f3, input logic jmp,
                       input logic [63:0] tgt, input logic pt, input logic [63:0] ptg,
                       input logic eq, input logic lt);
    resolve_valid    = 1'b1;
    resolve_pc       = pc;
    funct3           = f3;
    is_jump          = jmp;
    target           = tgt;
    pred_taken       = pt;
    pred_target      = ptg;
    branch_equals    = eq;
    branch_less_than = lt;
  endtask

  task automatic do_reset;
    idle_inputs();
    redirect_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    do_reset();
    lookup_pc = 64'h1000;
    #1;
    n_vec++; if (predict_taken !== 1'b0) begin n_err++; $display("FAIL reset_predict: got %b want 0", predict_taken); end
    n_vec++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL reset_rv: got %b want 0", redirect_valid); end
    n_vec++; if (mispredict_count !== 32'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", mispredict_count); end
    n_vec++; if (resolve_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", resolve_ready); end
    n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL reset_flush: got %b want 0", flush); end
    n_vec++; if (redirect_pc !== 64'h0) begin n_err++; $display("FAIL reset_rpc: got %h want 0", redirect_pc); end
  endtask

  task automatic test_beq_mispredict;
    lookup_pc = 64'h1000;
    redirect_ready = 1'b1;
    drive(64'h1000, 3'b000, 1'b0, 64'h1040, 1'b0, 64'h0, 1'b1, 1'b0);
    #1;
    n_vec++; if (branch_unsigned !== 1'b0) begin n_err++; $display("FAIL beq_unsigned: got %b want 0", branch_unsigned); end
    tick();
    idle_inputs();
    #1;
    n_vec++; if (redirect_valid !== 1'b1) begin n_err++; $display("FAIL beq_rv: got %b want 1", redirect_valid); end
    n_vec++; if (redirect_pc !== 64'h1040) begin n_err++; $display("FAIL beq_rpc: got %h want 1040", redirect_pc); end
    n_vec++; if (flush !== 1'b1) begin n_err++; $display("FAIL beq_flush: got %b want 1", flush); end
    n_vec++; if (mispredict_count !== 32'd1) begin n_err++; $display("FAIL beq_cnt: got %0d want 1", mispredict_count); end
    n_vec++; if (predict_taken !== 1'b1) begin n_err++; $display("FAIL beq_bht: got %b want 1", predict_taken); end
    tick();
    n_vec++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL beq_rv_clear: got %b want 0", redirect_valid); end
    n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL beq_flush_pulse: got %b want 0", flush); end
  endtask

  task automatic test_bgeu_hold;
    redirect_ready = 1'b0;
    drive(64'h2000, 3'b111, 1'b0, 64'h3000, 1'b1, 64'h3000, 1'b0, 1'b1);
    #1;
    n_vec++; if (branch_unsigned !== 1'b1) begin n_err++; $display("FAIL bgeu_unsigned: got %b want 1", branch_unsigned); end
    tick();
    // A mispredicting branch offered during the hold must be ignored.
    drive(64'h2000, 3'b000, 1'b0, 64'h5000, 1'b0, 64'h0, 1'b1, 1'b0);
    #1;
    n_vec++; if (redirect_valid !== 1'b1) begin n_err++; $display("FAIL bgeu_rv: got %b want 1", redirect_valid); end
    n_vec++; if (redirect_pc !== 64'h2004) begin n_err++; $display("FAIL bgeu_rpc: got %h want 2004", redirect_pc); end
    n_vec++; if (flush !== 1'b1) begin n_err++; $display("FAIL bgeu_flush: got %b want 1", flush); end
    n_vec++; if (resolve_ready !== 1'b0) begin n_err++; $display("FAIL bgeu_ready: got %b want 0", resolve_ready); end
    for (int c = 0; c < 2; c++) begin
      tick();
      n_vec++; if (redirect_valid !== 1'b1) begin n_err++; $display("FAIL hold_rv[%0d]: got %b want 1", c, redirect_valid); end
      n_vec++; if (redirect_pc !== 64'h2004) begin n_err++; $display("FAIL hold_rpc[%0d]: got %h want 2004", c, redirect_pc); end
      n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL hold_flush[%0d]: got %b want 0", c, flush); end
      n_vec++; if (resolve_ready !== 1'b0) begin n_err++; $display("FAIL hold_ready[%0d]: got %b want 0", c, resolve_ready); end
    end
    idle_inputs();
    redirect_ready = 1'b1;
    tick();
    lookup_pc = 64'h1000;
    #1;
    n_vec++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL hold_release: got %b want 0", redirect_valid); end
    n_vec++; if (mispredict_count !== 32'd2) begin n_err++; $display("FAIL hold_cnt: got %0d want 2", mispredict_count); end
    // Index 0 went 10 -> 01 from the not-taken BGEU; the ignored branch left it.
    n_vec++; if (predict_taken !== 1'b0) begin n_err++; $display("FAIL hold_bht: got %b want 0", predict_taken); end
  endtask

  task automatic test_saturate;
    logic outc [10];
    logic expp [10];
    logic tmp_o [10] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
    // Counter trajectory 01 ->10->11->11->11 ->10->01->00->00 ->01->10.
    logic tmp_p [10] = '{0, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    outc = tmp_o;
    expp = tmp_p;
    do_reset();
    lookup_pc = 64'h1104;
    for (int k = 0; k < 10; k++) begin
      drive(64'h1104, 3'b001, 1'b0, 64'h1200, outc[k], 64'h1200, !outc[k], 1'b0);
      #1;
      n_vec++; if (predict_taken !== expp[k]) begin n_err++; $display("FAIL sat_pred[%0d]: got %b want %b", k, predict_taken, expp[k]); end
      tick();
      n_vec++; if (flush !== 1'b0 || redirect_valid !== 1'b0) begin n_err++; $display("FAIL sat_noredir[%0d]: got %b%b want 00", k, flush, redirect_valid); end
    end
    idle_inputs();
    #1;
    n_vec++; if (predict_taken !== 1'b1) begin n_err++; $display("FAIL sat_final: got %b want 1", predict_taken); end
    n_vec++; if (mispredict_count !== 32'd0) begin n_err++; $display("FAIL sat_cnt: got %0d want 0", mispredict_count); end
  endtask

  task automatic test_jal;
    do_reset();
    lookup_pc = 64'h3008;
    drive(64'h3008, 3'b001, 1'b1, 64'h2004, 1'b1, 64'h2000, 1'b1, 1'b0);
    tick();
    idle_inputs();
    #1;
    n_vec++; if (redirect_valid !== 1'b1) begin n_err++; $display("FAIL jal_rv: got %b want 1", redirect_valid); end
    n_vec++; if (redirect_pc !== 64'h2004) begin n_err++; $display("FAIL jal_rpc: got %h want 2004", redirect_pc); end
    n_vec++; if (flush !== 1'b1) begin n_err++; $display("FAIL jal_flush: got %b want 1", flush); end
    n_vec++; if (mispredict_count !== 32'd1) begin n_err++; $display("FAIL jal_cnt: got %0d want 1", mispredict_count); end
    n_vec++; if (predict_taken !== 1'b0) begin n_err++; $display("FAIL jal_bht: got %b want 0", predict_taken); end
    tick();
  endtask

  task automatic test_illegal;
    // Train index 3 to strongly taken with two correctly predicted BEQs.
    lookup_pc = 64'h300C;
    for (int k = 0; k < 2; k++) begin
      drive(64'h300C, 3'b000, 1'b0, 64'h4000, 1'b1, 64'h4000, 1'b1, 1'b0);
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      drive(64'h300C, (k == 0) ? 3'b010 : 3'b011, 1'b0, 64'h4000, 1'b1, 64'h4000, 1'b1, 1'b1);
      tick();
      n_vec++; if (redirect_valid !== 1'b0 || flush !== 1'b0) begin n_err++; $display("FAIL illegal_redir[%0d]: got %b%b want 00", k, redirect_valid, flush); end
      n_vec++; if (mispredict_count !== 32'd1) begin n_err++; $display("FAIL illegal_cnt[%0d]: got %0d want 1", k, mispredict_count); end
    end
    idle_inputs();
    #1;
    n_vec++; if (predict_taken !== 1'b1) begin n_err++; $display("FAIL illegal_bht: got %b want 1", predict_taken); end
  endtask

  task automatic test_reset_mid_redirect;
    lookup_pc = 64'h1000;
    redirect_ready = 1'b0;
    drive(64'h1000, 3'b000, 1'b0, 64'h1040, 1'b0, 64'h0, 1'b1, 1'b0);
    tick();
    idle_inputs();
    n_vec++; if (redirect_valid !== 1'b1) begin n_err++; $display("FAIL mid_rv_pre: got %b want 1", redirect_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL mid_rv: got %b want 0", redirect_valid); end
    n_vec++; if (mispredict_count !== 32'd0) begin n_err++; $display("FAIL mid_cnt: got %0d want 0", mispredict_count); end
    n_vec++; if (predict_taken !== 1'b0) begin n_err++; $display("FAIL mid_bht: got %b want 0", predict_taken); end
    n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL mid_flush: got %b want 0", flush); end
    tick();
    rst_n = 1'b1;
    redirect_ready = 1'b1;
    #1;
  endtask

  task automatic test_random;
    int          bm [64];
    logic [31:0] cm;
    logic        rvm, flm;
    logic [63:0] rpm;
    logic        tk, lg, acc, mis;
    int          ui, li;
    do_reset();
    for (int i = 0; i < 64; i++) bm[i] = 1;
    cm = 0; rvm = 0; flm = 0; rpm = 0;
    for (int n = 0; n < 400; n++) begin
      resolve_valid    = ($urandom_range(0, 3) != 0);
      resolve_pc       = 64'(($urandom_range(0, 15) << 8) | ($urandom_range(0, 63) << 2));
      if ($urandom_range(0, 15) == 0) resolve_pc = 64'hFFFF_FFFF_FFFF_FFFC;
      funct3           = 3'($urandom_range(0, 7));
      is_jump          = ($urandom_range(0, 7) == 0);
      target           = {32'h0, $urandom} & ~64'h1;
      pred_taken       = $urandom_range(0, 1) == 1;
      pred_target      = ($urandom_range(0, 1) == 1) ? target : target + 64'd8;
      branch_equals    = $urandom_range(0, 1) == 1;
      branch_less_than = $urandom_range(0, 1) == 1;
      redirect_ready   = $urandom_range(0, 1) == 1;
      lookup_pc        = ($urandom_range(0, 1) == 1) ? resolve_pc : 64'($urandom_range(0, 4095) << 2);
      #1;
      li = int'(lookup_pc[7:2]);
      n_vec++; if (resolve_ready !== !rvm) begin n_err++; $display("FAIL rnd_ready[%0d]: got %b want %b", n, resolve_ready, !rvm); end
      n_vec++; if (predict_taken !== (bm[li] >= 2)) begin n_err++; $display("FAIL rnd_pred[%0d]: got %b want %b", n, predict_taken, bm[li] >= 2); end
      n_vec++; if (branch_unsigned !== (funct3 == 3'd6 || funct3 == 3'd7 || funct3 == 3'd2 || funct3 == 3'd3)) begin
        n_err++; $display("FAIL rnd_unsigned[%0d]: got %b f3 %0d", n, branch_unsigned, funct3); end
      // Reference outcome straight from the instruction semantics.
      lg = is_jump || !(funct3 == 3'd2 || funct3 == 3'd3);
      if (is_jump) tk = 1;
      else if (funct3 == 3'd0) tk = branch_equals;
      else if (funct3 == 3'd1) tk = !branch_equals;
      else if (funct3 == 3'd4 || funct3 == 3'd6) tk = branch_less_than;
      else if (funct3 == 3'd5 || funct3 == 3'd7) tk = !branch_less_than;
      else tk = 0;
      acc = resolve_valid && !rvm;
      mis = lg && ((pred_taken != tk) || (tk && pred_target != target));
      flm = 0;
      if (rvm) begin
        if (redirect_ready) rvm = 0;
      end else if (acc && mis) begin
        rvm = 1;
        flm = 1;
        rpm = tk ? target : resolve_pc + 64'd4;
        cm  = cm + 1;
      end
      if (acc && lg && !is_jump) begin
        ui = int'(resolve_pc[7:2]);
        bm[ui] = tk ? ((bm[ui] + 1 > 3) ? 3 : bm[ui] + 1) : ((bm[ui] - 1 < 0) ? 0 : bm[ui] - 1);
      end
      tick();
      n_vec++; if (redirect_valid !== rvm) begin n_err++; $display("FAIL rnd_rv[%0d]: got %b want %b", n, redirect_valid, rvm); end
      n_vec++; if (flush !== flm) begin n_err++; $display("FAIL rnd_flush[%0d]: got %b want %b", n, flush, flm); end
      n_vec++; if (mispredict_count !== cm) begin n_err++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", n, mispredict_count, cm); end
      if (rvm) begin
        n_vec++; if (redirect_pc !== rpm) begin n_err++; $display("FAIL rnd_rpc[%0d]: got %h want %h", n, redirect_pc, rpm); end
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_beq_mispredict();
    test_bgeu_hold();
    test_saturate();
    test_jal();
    test_illegal();
    test_reset_mid_redirect();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
